// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg
//   Shared types and constants for the PS/2 host-to-device transmitter.
//   - ps2_tx_state_t : transmitter FSM state encoding
//   - PS2_CMD_*      : common keyboard command bytes
//   - PS2_ACK_C      : byte the keyboard answers with after a command
//   - PS2_EDGE_*     : device clock falling-edge numbers within a frame
//   - PS2_GLITCH_HOLD: cycles a new clock level must persist when the
//                      glitch filter (PS2_TX_GLITCH_FILTER_EN) is built in
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK_C        = 8'hFA;

  // Edge n (1..8) puts data bit n-1 on the line, 9 the parity, 10 the stop
  // bit; on edge 11 the device answers with its ACK bit.
  localparam logic [3:0] PS2_EDGE_LAST_DATA = 4'd8;
  localparam logic [3:0] PS2_EDGE_PARITY    = 4'd9;
  localparam logic [3:0] PS2_EDGE_ACK       = 4'd11;

  localparam int PS2_GLITCH_HOLD = 8;

  // PS/2 frames carry odd parity: data bits plus parity bit hold an odd
  // number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// ps2_edge_filter
//   Brings an asynchronous PS/2 pin into the clk domain and flags its
//   falling edges.
//   Build option: PS2_TX_GLITCH_FILTER_EN -- when defined, the synchronised
//   level must hold a new value for PS2_GLITCH_HOLD consecutive cycles
//   before the filtered level follows it (adds that many cycles of edge
//   latency). When undefined the filtered level is the synchronised level.
//
//   clk        in  : system clock
//   rst        in  : asynchronous active-high reset
//   pin_in     in  : raw pin level (asynchronous)
//   level_sync out : 2-FF synchronised pin level
//   fall       out : one-cycle pulse, registered, the cycle after the
//                    filtered level goes 1->0
module ps2_edge_filter
  import ps2_host_tx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pin_in,
  output logic level_sync,
  output logic fall
);

  logic sync_meta;
  logic sync_q;
  logic filt_q;
  logic filt_prev;

  // Lines idle high through the pull-ups, so the synchroniser resets high to
  // avoid a spurious falling edge when reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
    end else begin
      sync_meta <= pin_in;
      sync_q    <= sync_meta;
    end
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic [2:0] hold_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= 3'd0;
      filt_q   <= 1'b1;
    end else if (sync_q == filt_q) begin
      hold_cnt <= 3'd0;
    end else if (hold_cnt == 3'(PS2_GLITCH_HOLD - 1)) begin
      filt_q   <= sync_q;
      hold_cnt <= 3'd0;
    end else begin
      hold_cnt <= hold_cnt + 3'd1;
    end
  end
`else
  assign filt_q = sync_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_prev <= 1'b1;
      fall      <= 1'b0;
    end else begin
      filt_prev <= filt_q;
      fall      <= filt_prev & ~filt_q;
    end
  end

  assign level_sync = sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Accepts one command byte, inhibits the
//   bus, issues request-to-send, shifts the frame out on the device's clock
//   and checks the device acknowledge. Open-drain pins are modelled as
//   output enables: oe = 1 pulls the line low, oe = 0 releases it.
//   Build option: PS2_TX_GLITCH_FILTER_EN enables the PS2_CLK glitch filter
//   inside ps2_edge_filter.
//
//   Parameters
//     INHIBIT_CYCLES : cycles PS2_CLK is held low before request-to-send
//     TIMEOUT_CYCLES : longest allowed gap between device clock falling
//                      edges (and from SEND entry to the first edge)
//   Ports
//     clk, rst                : system clock, async active-high reset
//     tx_valid/tx_ready       : command handshake (ready only in IDLE)
//     tx_data                 : command byte
//     ps2_clk_in, ps2_data_in : raw pin levels
//     ps2_clk_oe, ps2_data_oe : 1 = drive the line low
//     busy                    : transfer in progress
//     tx_done, tx_error       : one-cycle completion / failure pulses
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   IDLE       | lines released, ready for a command
//   INHIBIT    | PS2_CLK held low for INHIBIT_CYCLES cycles
//   REQ        | one cycle with PS2_CLK and PS2_DATA low (start bit)
//   SEND       | device clocks the frame out; ACK sampled on edge 11
//   WAIT_IDLE  | waiting for the device to release both lines
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] INHIBIT_LOAD = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_t    state_q;
  ps2_tx_state_t    state_d;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic [3:0]       edge_cnt_q;
  logic [3:0]       edge_next;
  logic [TMR_W-1:0] tmr_q;
  logic             tmr_zero;
  logic             data_drive_q;
  logic             drive_next;

  logic clk_sync;
  logic clk_fall;
  logic data_meta;
  logic data_sync;

  logic handshake;
  logic lines_idle;
  logic ack_edge;
  logic timeout;

  ps2_edge_filter u_clk_filter (
    .clk        (clk),
    .rst        (rst),
    .pin_in     (ps2_clk_in),
    .level_sync (clk_sync),
    .fall       (clk_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign handshake  = tx_valid && (state_q == ST_IDLE);
  assign lines_idle = clk_sync && data_sync;
  assign tmr_zero   = (tmr_q == '0);
  assign edge_next  = edge_cnt_q + 4'd1;
  assign ack_edge   = (state_q == ST_SEND) && clk_fall && (edge_next == PS2_EDGE_ACK);

  // A falling edge in the very cycle the timer expires still counts as the
  // device answering in time.
  assign timeout = tmr_zero &&
                   (((state_q == ST_SEND) && !clk_fall) ||
                    ((state_q == ST_WAIT_IDLE) && !lines_idle));

  // Level to put on PS2_DATA after the edge now being detected.
  always_comb begin
    drive_next = 1'b0;
    if (edge_next <= PS2_EDGE_LAST_DATA) begin
      drive_next = ~shift_q[0];
    end else if (edge_next == PS2_EDGE_PARITY) begin
      drive_next = ~parity_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (handshake) state_d = ST_INHIBIT;
      ST_INHIBIT:   if (tmr_zero) state_d = ST_REQ;
      ST_REQ:       state_d = ST_SEND;
      ST_SEND: begin
        if (ack_edge) begin
          state_d = data_sync ? ST_IDLE : ST_WAIT_IDLE;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_IDLE: if (lines_idle || timeout) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_ready    = 1'b0;
    busy        = 1'b1;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx_done     = 1'b0;
    tx_error    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
      end
      ST_REQ: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
      end
      ST_SEND: begin
        ps2_data_oe = data_drive_q;
        tx_error    = (ack_edge && data_sync) || timeout;
      end
      ST_WAIT_IDLE: begin
        tx_done  = lines_idle;
        tx_error = timeout;
      end
      default: begin
        tx_ready = 1'b0;
      end
    endcase
  end

  // One down-counter serves as inhibit timer and as edge-gap watchdog; the
  // two uses never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q      <= 8'd0;
      parity_q     <= 1'b0;
      edge_cnt_q   <= 4'd0;
      tmr_q        <= '0;
      data_drive_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            shift_q  <= tx_data;
            parity_q <= odd_parity(tx_data);
            tmr_q    <= INHIBIT_LOAD;
          end
        end
        ST_INHIBIT: begin
          if (!tmr_zero) tmr_q <= tmr_q - TMR_W'(1);
        end
        ST_REQ: begin
          edge_cnt_q   <= 4'd0;
          tmr_q        <= TIMEOUT_LOAD;
          data_drive_q <= 1'b1;
        end
        ST_SEND: begin
          if (clk_fall) begin
            edge_cnt_q   <= edge_next;
            tmr_q        <= TIMEOUT_LOAD;
            data_drive_q <= drive_next;
            if (edge_next <= PS2_EDGE_LAST_DATA) shift_q <= {1'b0, shift_q[7:1]};
          end else if (!tmr_zero) begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        ST_WAIT_IDLE: begin
          if (clk_fall) begin
            tmr_q <= TIMEOUT_LOAD;
          end else if (!tmr_zero) begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        default: begin
          tmr_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//   Scoreboard bench for ps2_host_tx. A PS/2 device model answers the host's
//   request-to-send, clocks the frame and records the line level on each
//   rising clock edge. Every command issued pushes its expected outcome and
//   frame (derived from the byte with plain arithmetic) into a queue; an
//   independent monitor pops and compares whenever tx_done/tx_error pulses.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INHIBIT = 40;
  localparam int TIMEOUT = 600;
  localparam int HALF    = 30;

  localparam int K_DONE = 0;
  localparam int K_NACK = 1;
  localparam int K_TMO  = 2;

  localparam int DEV_ACK    = 0;
  localparam int DEV_NACK   = 1;
  localparam int DEV_SILENT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  logic        dev_clk_low;
  logic        dev_data_low;
  logic        dev_active;
  logic        dev_glitch = 1'b0;
  int          dev_mode = DEV_SILENT;
  logic [10:0] dev_frame;

  typedef struct {
    int          kind;
    logic [10:0] frame;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame as seen on PS2_DATA: bit0 start, bits 1..8 data LSB first,
  // bit9 odd parity, bit10 stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int   ones = $countones(d);
    logic par  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic device_frame();
    dev_frame = '0;
    repeat (HALF) @(negedge clk);
    dev_frame[0] = ps2_data_in;
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && dev_mode == DEV_ACK) dev_data_low = 1'b1;
      if (dev_glitch && (i == 1 || i == 6)) begin
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (12) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i <= 10) dev_frame[i] = ps2_data_in;
      repeat (HALF) @(negedge clk);
    end
    dev_data_low = 1'b0;
    dev_active   = 1'b0;
  endtask

  initial begin : device_proc
    int guard;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    dev_active   = 1'b0;
    dev_frame    = '0;
    forever begin
      @(negedge clk);
      if (!rst && ps2_clk_oe && dev_mode != DEV_SILENT) begin
        dev_active = 1'b1;
        guard = 0;
        while (ps2_clk_oe && guard < 10000) begin
          @(negedge clk);
          guard++;
        end
        if (!rst && busy) device_frame();
        else dev_active = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_done || tx_error) begin
        check("done_error_exclusive", {31'd0, tx_done & tx_error}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual done=%0b error=%0b required=no pulse", tx_done, tx_error);
        end else begin
          e = exp_q.pop_front();
          check("outcome_done", {31'd0, tx_done}, {31'd0, e.kind == K_DONE});
          check("outcome_error", {31'd0, tx_error}, {31'd0, e.kind != K_DONE});
          if (e.kind != K_TMO) check("frame_bits", {21'd0, dev_frame}, {21'd0, e.frame});
          @(negedge clk);
          check("ready_after_pulse", {31'd0, tx_ready}, 32'd1);
          check("busy_after_pulse", {31'd0, busy}, 32'd0);
          check("lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input int mode, input logic glitch);
    exp_t e;
    int   n;
    int   dn;
    int   guard = 0;
    while (!tx_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_send", {31'd0, tx_ready}, 32'd1);
    dev_mode   = mode;
    dev_glitch = glitch;
    e.kind  = (mode == DEV_ACK) ? K_DONE : ((mode == DEV_NACK) ? K_NACK : K_TMO);
    e.frame = model_frame(d);
    exp_q.push_back(e);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    n  = 0;
    dn = 0;
    while (ps2_clk_oe && n < INHIBIT + 50) begin
      if (ps2_data_oe) dn++;
      n++;
      @(negedge clk);
    end
    check("clk_low_cycles", n, INHIBIT + 1);
    check("req_data_cycles", dn, 1);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || dev_active) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("frame_finishes", {31'd0, busy | dev_active}, 32'd0);
    repeat (5) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin : main
    int t;
    logic [7:0] d;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("reset_pulses", {30'd0, tx_done, tx_error}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send(PS2_CMD_SET_LEDS, DEV_ACK, 1'b0);
    wait_idle();
    send(8'h01, DEV_ACK, 1'b0);
    wait_idle();
    send(PS2_CMD_RESET, DEV_ACK, 1'b0);
    wait_idle();

    send(PS2_CMD_SET_LEDS, DEV_NACK, 1'b0);
    wait_idle();

    // No device clocks: send() returns on the first SEND cycle.
    send(PS2_CMD_RESET, DEV_SILENT, 1'b0);
    t = 1;
    while (!tx_error && t < TIMEOUT + 20) begin
      @(negedge clk);
      t++;
    end
    check("timeout_cycle", t, TIMEOUT);
    wait_idle();

    send(PS2_CMD_SET_LEDS, DEV_ACK, 1'b0);
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    repeat (100) @(negedge clk);
    check("busy_while_valid_ignored", {31'd0, busy}, 32'd1);
    check("not_ready_in_send", {31'd0, tx_ready}, 32'd0);
    tx_valid = 1'b0;
    wait_idle();

    dev_mode = DEV_SILENT;
    tx_valid = 1'b1;
    tx_data  = PS2_ACK_C;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("inhibit_before_reset", {31'd0, ps2_clk_oe}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("rst_mid_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_mid_pulses", {30'd0, tx_done, tx_error}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (INHIBIT + 10) @(negedge clk);
    check("idle_after_reset", {31'd0, busy}, 32'd0);

`ifdef PS2_TX_GLITCH_FILTER_EN
    send(PS2_CMD_SET_LEDS, DEV_ACK, 1'b1);
    wait_idle();
`endif

    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      send(d, ($urandom_range(0, 3) == 0) ? DEV_NACK : DEV_ACK, 1'b0);
      wait_idle();
    end

    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: serialises one command byte (e.g. 0xED set-LEDs, 0xFF reset) onto the keyboard's open-drain clock/data pair using the host request-to-send sequence, then checks the device acknowledge. It sits beside `ps2_keyboard` on the game clock domain, sharing the PS2_CLK/PS2_DATA pins. `busy` lets the receiver ignore the echo of its own frame.

## Interface
- `INHIBIT_CYCLES`, default 2500: clock-low inhibit length (100 µs at 25 MHz).
- `TIMEOUT_CYCLES`, default 375000: maximum gap between device clock falling edges, and between request and first edge (15 ms at 25 MHz).
- `clk`  in  1: game clock; sole clock.
- `rst`  in  1: asynchronous, active-high reset.
- `tx_valid`  in  1: command byte offered.
- `tx_data`  in  8: command byte.
- `tx_ready`  out  1: high only in IDLE; transfer accepted on `tx_valid && tx_ready`.
- `ps2_clk_in`  in  1: raw PS2_CLK pin level (asynchronous).
- `ps2_data_in`  in  1: raw PS2_DATA pin level (asynchronous).
- `ps2_clk_oe`  out  1: 1 = drive PS2_CLK low; 0 = release (pull-up).
- `ps2_data_oe`  out  1: 1 = drive PS2_DATA low; 0 = release.
- `busy`  out  1: state != IDLE.
- `tx_done`  out  1: one-cycle pulse, frame sent and ACK received.
- `tx_error`  out  1: one-cycle pulse, timeout or missing ACK.

## Operation
- States: IDLE, INHIBIT, REQ, SEND, WAIT_IDLE.
- IDLE: both oe = 0, tx_ready = 1. On handshake latch `tx_data`, compute odd parity `~^tx_data`, go INHIBIT.
- INHIBIT: `ps2_clk_oe`=1 for exactly INHIBIT_CYCLES cycles, then REQ.
- REQ (1 cycle): `ps2_clk_oe`=1, `ps2_data_oe`=1 (start bit 0). Then SEND.
- SEND: `ps2_clk_oe`=0. 4-bit edge counter n counts detected falling edges of filtered PS2_CLK. After edge n=1..8 drive data bit n-1 (LSB first); after n=9 drive parity; after n=10 release data (stop bit 1). `ps2_data_oe` = inverse of the bit being sent. On edge 11 sample data: 0 = ACK, go WAIT_IDLE; 1 = NACK, pulse `tx_error`, go IDLE.
- WAIT_IDLE: wait for synchronised clk and data both high, pulse `tx_done`, go IDLE.
- Timeout counter clears on every falling edge and on entry to SEND; reaching TIMEOUT_CYCLES in SEND or WAIT_IDLE releases both lines, pulses `tx_error`, returns IDLE.
- `tx_valid` outside IDLE is ignored (not queued).
- Rising edges and data-line activity outside SEND ignored.

## Timing
- Reset (async): state IDLE, all oe 0, `tx_ready`=1, `busy`=0, `tx_done`=`tx_error`=0, counters 0.
- Reset mid-frame releases both lines on the asserting edge; no pulse is emitted.
- Pin inputs pass a 2-FF synchroniser; falling edge detected the cycle after the synchronised value goes 1→0 (3 cycles after pin change without filter).
- `ps2_data_oe` updates on the cycle following edge detection; ACK sampled from the synchronised data on the 11th-edge detection cycle.
- Handshake cycle → INHIBIT next cycle; `ps2_clk_oe` high INHIBIT_CYCLES+1 cycles total (including REQ).
- `tx_done`/`tx_error` never both high; `tx_ready` returns the cycle after the pulse.

## Configuration
- `PS2_TX_GLITCH_FILTER_EN` defined: synchronised PS2_CLK must hold a new level for 8 consecutive cycles before the filtered level changes (edge detection latency +8 cycles).
- Undefined: filtered level = synchronised level; no added latency.

## Structure
- Shared package/GLOBAL: `ps2_tx_state_t` enum; `PS2_CMD_SET_LEDS` (8'hED), `PS2_CMD_RESET` (8'hFF), `PS2_ACK_C` (8'hFA).
- Sub-module `ps2_edge_filter`: synchroniser, optional glitch filter, falling-edge pulse; instanced for PS2_CLK (data uses sync only).

## Test plan
- Reset asserted mid-INHIBIT → both oe 0 immediately, `tx_ready`=1, no pulse.
- Send 0xED with device model clocking at 12.5 kHz, ACK low → data_oe after edges 1–10: 0,1,0,0,1,0,0,0,0 (parity 1),0; `tx_done` once, `busy` low after.
- Send 0x01 → parity bit 0 (`ps2_data_oe`=1 after edge 9); 0xFF → parity 1.
- Device leaves data high on edge 11 → `tx_error` pulse, no `tx_done`, lines released.
- No device clocks after REQ → `tx_error` exactly TIMEOUT_CYCLES after SEND entry.
- `tx_valid` with 0x55 during SEND of 0xED → ignored; serialised bits remain 0xED. With filter on, 3-cycle clock glitch → no edge counted.
